rv_alu2: RTL

Second execute stage of the FlexRV32 pipeline. Registers the operand bundle produced by the first execute stage and computes the integer ALU result. Evaluates branch conditions, issues the PC redirect, and forwards store/writeback control to the memory stage. An optional serial shifter trades area for multi-cycle shift latency; the stage stalls upstream while it runs.

---
 rtl/rv_alu2_pkg.sv | 65 ++++++
 rtl/rv_alu2_if.sv | 32 +++
 rtl/rv_alu2_shifter.sv | 130 +++++++++++++
 rtl/rv_alu2.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rv_alu2_pkg.sv
// rv_alu2_pkg
// Shared types for the second execute stage: the operand bundle coming from
// the first execute stage (alu1_bus_t), the bundle handed to the memory stage
// (alu2_bus_t), ALU operation / result-source encodings and branch funct3
// constants.
package rv_alu2_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_t;

    typedef enum logic {
        RES_ALU = 1'b0,
        RES_OP2 = 1'b1
    } alu_res_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        alu_res_t    alu_res;
        alu_ctrl_t   alu_ctrl;
        logic        store;
        logic        reg_write;
        logic [4:0]  rd;
        logic        inst_jal_jalr;
        logic        inst_branch;
        logic [31:0] pc_p4;
        logic [31:0] pc_target;
        logic [1:0]  res_src;
        logic [2:0]  funct3;
        logic [31:0] reg_data2;
    } alu1_bus_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] reg_data2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        store;
        logic [1:0]  res_src;
        logic [2:0]  funct3;
        logic [31:0] pc_p4;
    } alu2_bus_t;

    function automatic logic is_shift(alu_ctrl_t ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/rv_alu2_if.sv
// rv_alu2_if
// Pipeline-side signals of the second execute stage.
//   i_stall     : downstream stall, holds the stage
//   i_flush     : turn the instruction being captured into a bubble
//   i_bus       : operand bundle from execute stage 1
//   o_bus       : result bundle to the memory stage
//   o_pc_select : redirect fetch to o_pc_target
//   o_pc_target : registered branch/jump target
//   o_busy      : serial shift in progress, upstream holds i_bus
// master = pipeline side driving the stage, slave = the stage itself.
interface rv_alu2_if;
    import rv_alu2_pkg::*;

    logic        i_stall;
    logic        i_flush;
    alu1_bus_t   i_bus;
    alu2_bus_t   o_bus;
    logic        o_pc_select;
    logic [31:0] o_pc_target;
    logic        o_busy;

    modport master (
        output i_stall, i_flush, i_bus,
        input  o_bus, o_pc_select, o_pc_target, o_busy
    );

    modport slave (
        input  i_stall, i_flush, i_bus,
        output o_bus, o_pc_select, o_pc_target, o_busy
    );

endinterface

// File: rtl/rv_alu2_shifter.sv
// rv_alu2_shifter
// Shift unit of the second execute stage.
//   SERIAL_SHIFT = 0 : combinational barrel shift of the registered operands,
//                      done is held high.
//   SERIAL_SHIFT = 1 : one bit per non-stalled cycle. start loads the working
//                      register from the operands being captured; busy is high
//                      while shifting; done is high in the cycle that presents
//                      the finished value (held while stalled).
// Ports: i_clk, i_reset_n (sync, active-low), stall, flush, start,
//        load_op1/load_shamt/load_ctrl (operands being captured),
//        op1/shamt/ctrl (registered operands), result, busy, done.
//
// state    | meaning
// ---------+---------------------------------------------------------
// SH_IDLE  | no shift running; done marks a freshly finished result
// SH_SHIFT | shifting one bit per non-stalled cycle, cnt bits left
module rv_alu2_shifter
    import rv_alu2_pkg::*;
#(
    parameter bit SERIAL_SHIFT = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        start,
    input  logic [31:0] load_op1,
    input  logic [4:0]  load_shamt,
    input  alu_ctrl_t   load_ctrl,
    input  logic [31:0] op1,
    input  logic [4:0]  shamt,
    input  alu_ctrl_t   ctrl,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        SH_IDLE  = 1'b0,
        SH_SHIFT = 1'b1
    } sh_state_t;

    sh_state_t   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] work_q, work_d;
    alu_ctrl_t   kind_q, kind_d;
    logic        done_q, done_d;
    logic        start_en;
    logic [31:0] barrel;

    function automatic logic [31:0] step1(logic [31:0] v, alu_ctrl_t c);
        logic [31:0] r;
        case (c)
            ALU_SLL: r = {v[30:0], 1'b0};
            ALU_SRA: r = {v[31], v[31:1]};
            default: r = {1'b0, v[31:1]};
        endcase
        return r;
    endfunction

    always_comb begin
        barrel = op1;
        case (ctrl)
            ALU_SLL: barrel = op1 << shamt;
            ALU_SRL: barrel = op1 >> shamt;
            ALU_SRA: barrel = $unsigned($signed(op1) >>> shamt);
            default: barrel = op1;
        endcase
    end

    assign start_en = start && SERIAL_SHIFT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        kind_d  = kind_q;
        done_d  = done_q;
        case (state_q)
            SH_IDLE: begin
                if (!stall) begin
                    done_d = 1'b0;
                end
                if (start_en) begin
                    state_d = SH_SHIFT;
                    cnt_d   = load_shamt;
                    work_d  = load_op1;
                    kind_d  = load_ctrl;
                end
            end
            SH_SHIFT: begin
                // A flush aborts the running shift even under stall.
                if (flush) begin
                    state_d = SH_IDLE;
                    cnt_d   = 5'd0;
                end else if (!stall) begin
                    work_d = step1(work_q, kind_q);
                    cnt_d  = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = SH_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = SH_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= SH_IDLE;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        work_q <= work_d;
        kind_q <= kind_d;
    end

    assign busy   = (state_q == SH_SHIFT);
    assign result = SERIAL_SHIFT ? work_q : barrel;
    assign done   = SERIAL_SHIFT ? done_q : 1'b1;

endmodule

// File: rtl/rv_alu2.sv
// rv_alu2
// Second execute stage: registers the execute-1 operand bundle, computes the
// ALU result, evaluates the branch condition and issues the PC redirect, and
// forwards store/writeback control to the memory stage.
// Ports: i_clk, i_reset_n (sync, active-low), alu_if (rv_alu2_if.slave).
// Parameter SERIAL_SHIFT selects barrel (0) or 1-bit-per-cycle shifter (1).
module rv_alu2
    import rv_alu2_pkg::*;
#(
    parameter bit SERIAL_SHIFT = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    rv_alu2_if.slave   alu_if
);

    alu1_bus_t   stage_q;
    logic        cap;
    logic        busy;
    logic        sh_start;
    logic        sh_done;
    logic [31:0] sh_result;
    logic [31:0] shift_res;
    logic [31:0] alu_out;
    logic [31:0] result;
    logic        cond;

    assign cap      = !alu_if.i_stall && !busy;
    assign sh_start = cap && !alu_if.i_flush && is_shift(alu_if.i_bus.alu_ctrl)
                      && (alu_if.i_bus.op2[4:0] != 5'd0);

    // Only the control bits are reset; a flush (on capture, or while a serial
    // shift is running) turns the stage into a bubble.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            stage_q.reg_write     <= 1'b0;
            stage_q.store         <= 1'b0;
            stage_q.inst_branch   <= 1'b0;
            stage_q.inst_jal_jalr <= 1'b0;
        end else if (cap) begin
            stage_q <= alu_if.i_bus;
            if (alu_if.i_flush) begin
                stage_q.reg_write     <= 1'b0;
                stage_q.store         <= 1'b0;
                stage_q.inst_branch   <= 1'b0;
                stage_q.inst_jal_jalr <= 1'b0;
            end
        end else if (busy && alu_if.i_flush) begin
            stage_q.reg_write     <= 1'b0;
            stage_q.store         <= 1'b0;
            stage_q.inst_branch   <= 1'b0;
            stage_q.inst_jal_jalr <= 1'b0;
        end
    end

    rv_alu2_shifter #(
        .SERIAL_SHIFT (SERIAL_SHIFT)
    ) u_shifter (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .stall      (alu_if.i_stall),
        .flush      (alu_if.i_flush),
        .start      (sh_start),
        .load_op1   (alu_if.i_bus.op1),
        .load_shamt (alu_if.i_bus.op2[4:0]),
        .load_ctrl  (alu_if.i_bus.alu_ctrl),
        .op1        (stage_q.op1),
        .shamt      (stage_q.op2[4:0]),
        .ctrl       (stage_q.alu_ctrl),
        .result     (sh_result),
        .busy       (busy),
        .done       (sh_done)
    );

    // A serial shift with shamt = 0 never starts, so done stays low and the
    // result is op1 unchanged.
    assign shift_res = sh_done ? sh_result : stage_q.op1;

    always_comb begin
        alu_out = 32'd0;
        case (stage_q.alu_ctrl)
            ALU_ADD:  alu_out = stage_q.op1 + stage_q.op2;
            ALU_SUB:  alu_out = stage_q.op1 - stage_q.op2;
            ALU_SLT:  alu_out = {31'd0, $signed(stage_q.op1) < $signed(stage_q.op2)};
            ALU_SLTU: alu_out = {31'd0, stage_q.op1 < stage_q.op2};
            ALU_XOR:  alu_out = stage_q.op1 ^ stage_q.op2;
            ALU_OR:   alu_out = stage_q.op1 | stage_q.op2;
            ALU_AND:  alu_out = stage_q.op1 & stage_q.op2;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_out = shift_res;
            default:  alu_out = 32'd0;
        endcase
    end

    always_comb begin
        result = alu_out;
        if (stage_q.inst_jal_jalr) begin
            result = stage_q.pc_p4;
        end else if (stage_q.alu_res == RES_OP2) begin
            result = stage_q.op2;
        end
    end

    always_comb begin
        cond = 1'b0;
        case (stage_q.funct3)
            F3_BEQ:  cond = (stage_q.op1 == stage_q.op2);
            F3_BNE:  cond = (stage_q.op1 != stage_q.op2);
            F3_BLT:  cond = ($signed(stage_q.op1) <  $signed(stage_q.op2));
            F3_BGE:  cond = ($signed(stage_q.op1) >= $signed(stage_q.op2));
            F3_BLTU: cond = (stage_q.op1 <  stage_q.op2);
            F3_BGEU: cond = (stage_q.op1 >= stage_q.op2);
            default: cond = 1'b0;
        endcase
    end

    assign alu_if.o_pc_select = !busy && (stage_q.inst_jal_jalr || (stage_q.inst_branch && cond));
    assign alu_if.o_pc_target = stage_q.pc_target;
    assign alu_if.o_busy      = busy;

    always_comb begin
        alu_if.o_bus.result    = result;
        alu_if.o_bus.reg_data2 = stage_q.reg_data2;
        alu_if.o_bus.rd        = stage_q.rd;
        alu_if.o_bus.reg_write = stage_q.reg_write && !busy;
        alu_if.o_bus.store     = stage_q.store && !busy;
        alu_if.o_bus.res_src   = stage_q.res_src;
        alu_if.o_bus.funct3    = stage_q.funct3;
        alu_if.o_bus.pc_p4     = stage_q.pc_p4;
    end

endmodule
